noc_inject_scheduler: RTL and testbench
=======================================

// Module: noc_inject_scheduler
// PURPOSE
//  Sequences test-packet injection into the NoC routers. Queues (router index, payload)
//  commands and drives one router slot at a time on a flat per-router bus. Holds each
//  packet until that router accepts it, then inserts an idle gap before the next one.
//  Sits between the board-level data/router selector and the router array.
// PARAMETERS
//  NUM_ROUTERS  81   routers in the network; number of slots on the bus
//  PKT_W        15   slot width: bit PKT_W-1 = valid/emulation flag, bits PKT_W-2:0 = two step counts
//  IDX_W        7    router index width (needs 2**IDX_W >= NUM_ROUTERS)
//  FIFO_DEPTH   4    command queue depth (power of 2)
//  GAP_CYCLES   2    all-zero bus cycles after each packet (>=1)
//  TIMEOUT      255  DRIVE cycles without router ready before the packet is dropped
// PORTS
//  clk            in   1                  clock, rising edge
//  rst_n          in   1                  asynchronous reset, active low
//  enable         in   1                  allows new packets to start (from sw_on)
//  cmd_valid      in   1                  command present
//  cmd_ready      out  1                  queue can accept; equals !full
//  cmd_router     in   IDX_W              target router index, 0-based
//  cmd_data       in   PKT_W-1            payload without the flag bit
//  rtr_ready      in   NUM_ROUTERS        per-router accept strobe
//  out_to_router  out  NUM_ROUTERS*PKT_W  slot i = bits [i*PKT_W +: PKT_W]
//  busy           out  1                  FSM is not IDLE, or the queue is non-empty
//  inj_count      out  16                 count of packets accepted by routers
//  err_timeout    out  1                  sticky: a packet was dropped after TIMEOUT
//  err_bad_index  out  1                  sticky: a command had cmd_router >= NUM_ROUTERS
// BEHAVIOUR
//  - Reset (async, rst_n=0): queue empty; FSM IDLE; out_to_router=0; inj_count=0; both
//    err flags=0; cmd_ready=1; busy=0. Reset in the middle of a packet clears the bus at once.
//  - Accept: on a edge with cmd_valid&&cmd_ready. A bad index is not queued and sets
//    err_bad_index. A push while full is refused: cmd_ready=0, even if a pop occurs the same cycle.
//  - FSM states IDLE, DRIVE, GAP. All outputs are registered.
//    IDLE : if enable && !empty -> pop, load slot[idx]={1'b1,data}, go to DRIVE.
//           Every other slot = 0.
//    DRIVE: hold the slot. On an edge with rtr_ready[idx]=1 -> clear the bus, inj_count++
//           (wraps from 0xFFFF to 0), go to GAP. Once the wait counter reaches TIMEOUT ->
//           clear the bus, set err_timeout, no count, go to GAP.
//    GAP  : bus = 0 for GAP_CYCLES cycles, then go to IDLE.
//  - Latency: a command accepted at edge E0 into an idle, empty scheduler with enable=1
//    drives the bus after E1. The slot is valid for at least 1 cycle.
//  - Dropping enable in DRIVE or GAP does not abort the current packet. It only blocks the next pop.
//  - rtr_ready on non-target routers is ignored. At most one slot is non-zero at any time.
//  - Wait counter width = clog2(TIMEOUT+1). It is cleared on entry to DRIVE.
// CONFIGURATION
//  AUTO_SWEEP_EN defined:
//   - Adds inputs sweep_start (1 bit) and sweep_data (PKT_W-1 bits).
//   - A sweep_start sample in IDLE with the queue empty and enable=1 injects sweep_data to
//     routers 0..NUM_ROUTERS-1 in order. Each one uses the DRIVE/GAP rules.
//   - Commands are still queued during a sweep. They are served after the last router.
//   - sweep_start during a sweep is ignored. busy stays 1 for the whole sweep.
//  AUTO_SWEEP_EN undefined: these ports and the sweep logic do not exist.
// STRUCTURE
//  - Package noc_inj_pkg: PKT_W, IDX_W defaults; state enum {IDLE,DRIVE,GAP}; slot_t
//    packed struct {flag, data}; localparam FLAG_BIT.
//  - Sub-module noc_inj_fifo: synchronous FIFO, width IDX_W+PKT_W-1, depth FIFO_DEPTH,
//    full/empty flags, async active-low reset.
//  - The top holds the FSM, counters and bus register. The bus is built with a generate loop.
// TESTING
//  1. Reset, then push (router=5, data=14'h0123). rtr_ready[5]=1 on the 3rd DRIVE cycle ->
//     slot5=15'h4123 for 3 cycles, then 0. inj_count=1. All other slots stay 0.
//  2. Push 5 commands with rtr_ready=0 -> the 5th sees cmd_ready=0 while full.
//     After that, the first 4 are served in order.
//  3. Target 80 with rtr_ready tied 0 -> slot80 held for 255 cycles, then cleared;
//     err_timeout=1; inj_count unchanged.
//  4. Push router=81 -> not queued, err_bad_index=1, bus stays 0.
//     Push router=0 -> injected normally.
//  5. enable=0 with 2 commands queued -> bus 0 and busy=1.
//     Raise enable -> both are injected with a 2-cycle gap between them.
//  6. Assert rst_n=0 during DRIVE -> bus 0 asynchronously, inj_count=0, queue empty.
//     AUTO_SWEEP_EN: one sweep with rtr_ready all 1 -> inj_count=81.

Source files
------------

// File: rtl/noc_inj_pkg.sv
// Shared types and default widths for the NoC test-packet injection scheduler.
package noc_inj_pkg;

    localparam int DEF_PKT_W = 15;
    localparam int DEF_IDX_W = 7;
    localparam int FLAG_BIT  = DEF_PKT_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                   flag;
        logic [DEF_PKT_W-2:0]   data;
    } slot_t;

    function automatic slot_t make_slot(input logic [DEF_PKT_W-2:0] data);
        slot_t s;
        s.flag = 1'b1;
        s.data = data;
        return s;
    endfunction

endpackage

// File: rtl/noc_inj_fifo.sv
// Synchronous command FIFO with registered full/empty flags; DEPTH must be a power of 2.
module noc_inj_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // A push while full is refused even if a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: default assignment first so every path assigns and no latch is inferred.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: storage is not reset; only the pointers and flags decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/noc_inject_scheduler.sv
// Queues (router, payload) commands and drives one router slot at a time, with idle gaps.
// Optional build macro AUTO_SWEEP_EN adds a one-shot sweep over all routers.
module noc_inject_scheduler
    import noc_inj_pkg::*;
#(
    parameter int NUM_ROUTERS = 81,
    parameter int PKT_W       = DEF_PKT_W,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [IDX_W-1:0]             cmd_router,
    input  logic [PKT_W-2:0]             cmd_data,
    input  logic [NUM_ROUTERS-1:0]       rtr_ready,
`ifdef AUTO_SWEEP_EN
    input  logic                         sweep_start,
    input  logic [PKT_W-2:0]             sweep_data,
`endif
    output logic [NUM_ROUTERS*PKT_W-1:0] out_to_router,
    output logic                         busy,
    output logic [15:0]                  inj_count,
    output logic                         err_timeout,
    output logic                         err_bad_index
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int CMD_W  = IDX_W + PKT_W - 1;

    state_e             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   cur_idx;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [CMD_W-1:0]   fifo_rdata;
    logic               cmd_fire;
    logic               cmd_ok;

    logic               load;
    logic [IDX_W-1:0]   load_idx;
    logic [PKT_W-2:0]   load_data;
    logic               clear_bus;
    logic               accepted;
    logic               timed_out;

`ifdef AUTO_SWEEP_EN
    logic               sweep_active;
    logic [IDX_W-1:0]   sweep_idx;
    logic [PKT_W-2:0]   sweep_payload;
    logic               sweep_go;
    logic               sweep_step;
`endif

    assign cmd_ready = !fifo_full;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_ok    = (cmd_router < IDX_W'(NUM_ROUTERS));
    assign fifo_push = cmd_fire && cmd_ok;

    noc_inj_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({cmd_router, cmd_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        fifo_pop  = 1'b0;
        load      = 1'b0;
        load_idx  = fifo_rdata[CMD_W-1 -: IDX_W];
        load_data = fifo_rdata[PKT_W-2:0];
        clear_bus = 1'b0;
        accepted  = 1'b0;
        timed_out = 1'b0;
`ifdef AUTO_SWEEP_EN
        sweep_go   = 1'b0;
        sweep_step = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
`ifdef AUTO_SWEEP_EN
                // A running sweep owns the bus until its last router; queued commands wait.
                if (sweep_active) begin
                    if (enable) begin
                        load       = 1'b1;
                        sweep_step = 1'b1;
                        load_idx   = sweep_idx;
                        load_data  = sweep_payload;
                    end
                end else if (enable && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                end else if (enable && sweep_start) begin
                    load      = 1'b1;
                    sweep_go  = 1'b1;
                    load_idx  = '0;
                    load_data = sweep_data;
                end
`else
                if (enable && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                end
`endif
            end
            ST_DRIVE: begin
                // Router acceptance wins over a timeout expiring on the same edge.
                if (rtr_ready[cur_idx]) begin
                    clear_bus = 1'b1;
                    accepted  = 1'b1;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    clear_bus = 1'b1;
                    timed_out = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            gap_cnt       <= '0;
            cur_idx       <= '0;
            inj_count     <= '0;
            err_timeout   <= 1'b0;
            err_bad_index <= 1'b0;
        end else begin
            if (cmd_fire && !cmd_ok) err_bad_index <= 1'b1;
            if (timed_out)           err_timeout   <= 1'b1;
            if (accepted)            inj_count     <= inj_count + 16'd1;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state    <= ST_DRIVE;
                        cur_idx  <= load_idx;
                        wait_cnt <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (clear_bus) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state <= ST_IDLE;
                    else                                   gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AUTO_SWEEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_active  <= 1'b0;
            sweep_idx     <= '0;
            sweep_payload <= '0;
        end else if (sweep_go) begin
            sweep_active  <= (NUM_ROUTERS > 1);
            sweep_idx     <= IDX_W'(1);
            sweep_payload <= sweep_data;
        end else if (sweep_step) begin
            if (sweep_idx == IDX_W'(NUM_ROUTERS - 1)) sweep_active <= 1'b0;
            else                                     sweep_idx    <= sweep_idx + 1'b1;
        end
    end

    assign busy = (state != ST_IDLE) || !fifo_empty || sweep_active;
`else
    assign busy = (state != ST_IDLE) || !fifo_empty;
`endif

    // One register per slot, so the bus is registered and cleared directly by reset.
    for (genvar i = 0; i < NUM_ROUTERS; i++) begin : g_slot
        logic [PKT_W-1:0] slot;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot <= '0;
            end else if (load && (load_idx == IDX_W'(i))) begin
                slot <= {1'b1, load_data};
            end else if (clear_bus) begin
                slot <= '0;
            end
        end

        assign out_to_router[i*PKT_W +: PKT_W] = slot;
    end

endmodule

// File: tb/tb_noc_inject_scheduler.sv
// Scoreboard bench for noc_inject_scheduler: stimulus queues expected packets, a negedge
// monitor tracks each slot pulse, answers with rtr_ready and compares against the queue.
module tb_noc_inject_scheduler;

    localparam int NR   = 81;
    localparam int PW   = 15;
    localparam int GAPC = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [6:0]      cmd_router = '0;
    logic [13:0]     cmd_data = '0;
    logic [NR-1:0]   rtr_ready = '0;
    logic [NR*PW-1:0] out_to_router;
    logic            busy;
    logic [15:0]     inj_count;
    logic            err_timeout;
    logic            err_bad_index;
`ifdef AUTO_SWEEP_EN
    logic            sweep_start = 1'b0;
    logic [13:0]     sweep_data = '0;
`endif

    noc_inject_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_router    (cmd_router),
        .cmd_data      (cmd_data),
        .rtr_ready     (rtr_ready),
`ifdef AUTO_SWEEP_EN
        .sweep_start   (sweep_start),
        .sweep_data    (sweep_data),
`endif
        .out_to_router (out_to_router),
        .busy          (busy),
        .inj_count     (inj_count),
        .err_timeout   (err_timeout),
        .err_bad_index (err_bad_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [14:0] val;
        int          hold;   // -1: don't care (packet cut short by reset)
        int          gap;    // -1: don't care
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Responder controls: target answers on its ready_delay-th visible cycle (0 = never).
    int   ready_delay = 0;
    bit   ready_all   = 1'b0;
    bit   noise       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_pkt(input int idx, input logic [13:0] d, input int hold, input int gap);
        exp_t e;
        e.idx  = idx;
        e.val  = {1'b1, d};
        e.hold = hold;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic push(input int r, input logic [13:0] d, output bit acc);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_router = r[6:0];
        cmd_data   = d;
        acc        = cmd_ready;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Monitor + responder
    bit          act = 1'b0;
    int          cur_idx = 0;
    int          held = 0;
    int          zeros = 1000;
    int          gap_seen = 0;
    logic [14:0] cur_val = '0;

    always @(negedge clk) begin
        int          nz;
        int          idx;
        logic [14:0] v;
        exp_t        e;
        nz  = 0;
        idx = 0;
        v   = '0;
        for (int i = 0; i < NR; i++) begin
            if (out_to_router[i*PW +: PW] != '0) begin
                nz++;
                idx = i;
                v   = out_to_router[i*PW +: PW];
            end
        end
        if (nz > 1) check("one_slot_active", nz, 1);
        if (nz > 0 && !act) begin
            act      = 1'b1;
            cur_idx  = idx;
            cur_val  = v;
            held     = 1;
            gap_seen = zeros;
        end else if (nz > 0) begin
            if (idx != cur_idx) check("slot_stable_idx", idx, cur_idx);
            if (v !== cur_val)  check("slot_stable_val", {17'd0, v}, {17'd0, cur_val});
            held++;
        end else if (act) begin
            act   = 1'b0;
            zeros = 1;
            if (exp_q.size() == 0) begin
                check("unexpected_pkt_router", cur_idx, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pkt_router", cur_idx, e.idx);
                check("pkt_value", {17'd0, cur_val}, {17'd0, e.val});
                if (e.hold >= 0) check("pkt_hold", held, e.hold);
                if (e.gap >= 0)  check("pkt_gap", gap_seen, e.gap);
            end
        end else begin
            zeros++;
        end

        rtr_ready = '0;
        if (ready_all) begin
            rtr_ready = '1;
        end else begin
            if (noise) begin
                rtr_ready[4] = 1'b1;
                rtr_ready[6] = 1'b1;
            end
            if (act && ready_delay > 0 && held == ready_delay) rtr_ready[cur_idx] = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bus", {31'd0, |out_to_router}, 32'd0);
        check("rst_inj_count", inj_count, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_bad_index", err_bad_index, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // 1: single packet, ready on 3rd DRIVE cycle, neighbours' ready ignored
        noise       = 1'b1;
        ready_delay = 3;
        expect_pkt(5, 14'h0123, 3, -1);
        push(5, 14'h0123, acc);
        check("t1_accept", acc, 1);
        check("t1_bus_zero_before_e1", {31'd0, |out_to_router}, 32'd0);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_slot5_after_e1", {17'd0, out_to_router[5*PW +: PW]}, 32'h4123);
        wait_idle("t1", 50);
        noise = 1'b0;
        check("t1_inj_count", inj_count, 1);

        // 2: fill the queue with enable low; the 5th push is refused
        enable      = 1'b0;
        ready_delay = 2;
        for (int k = 0; k < 5; k++) begin
            push(10 + k, 14'h0100 + 14'(k), acc);
            check("t2_accept", acc, (k < 4) ? 1 : 0);
            if (k < 4) expect_pkt(10 + k, 14'h0100 + 14'(k), 2, (k == 0) ? -1 : GAPC + 1);
        end
        check("t2_cmd_ready_full", cmd_ready, 0);
        enable = 1'b1;
        wait_idle("t2", 200);
        check("t2_inj_count", inj_count, 5);

        // 3: no ready from router 80 -> 255-cycle hold then drop
        check("t3_err_timeout_pre", err_timeout, 0);
        ready_delay = 0;
        expect_pkt(80, 14'h2AAA, 255, -1);
        push(80, 14'h2AAA, acc);
        wait_idle("t3", 400);
        check("t3_err_timeout", err_timeout, 1);
        check("t3_inj_count", inj_count, 5);

        // 4: out-of-range index rejected, then router 0 injected
        push(81, 14'h1111, acc);
        check("t4_bad_err", err_bad_index, 1);
        check("t4_bad_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("t4_bad_bus", {31'd0, |out_to_router}, 32'd0);
        ready_delay = 1;
        expect_pkt(0, 14'h3FFF, 1, -1);
        push(0, 14'h3FFF, acc);
        wait_idle("t4", 50);
        check("t4_inj_count", inj_count, 6);

        // 5: enable low holds two queued commands; raising it injects both
        enable = 1'b0;
        push(20, 14'h0055, acc);
        push(21, 14'h00AA, acc);
        repeat (5) @(negedge clk);
        check("t5_hold_busy", busy, 1);
        check("t5_hold_bus", {31'd0, |out_to_router}, 32'd0);
        expect_pkt(20, 14'h0055, 1, -1);
        expect_pkt(21, 14'h00AA, 1, GAPC + 1);
        enable = 1'b1;
        wait_idle("t5", 50);
        check("t5_inj_count", inj_count, 8);

        // 6: reset in DRIVE with one more command queued
        ready_delay = 0;
        expect_pkt(7, 14'h0777, -1, -1);
        push(7, 14'h0777, acc);
        push(8, 14'h0888, acc);
        n = 0;
        while (out_to_router[7*PW +: PW] == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_slot7_driven", {17'd0, out_to_router[7*PW +: PW]}, 32'h4777);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_bus", {31'd0, |out_to_router}, 32'd0);
        check("t6_rst_inj_count", inj_count, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cmd_ready", cmd_ready, 1);
        check("t6_rst_err_timeout", err_timeout, 0);
        check("t6_rst_err_bad_index", err_bad_index, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_queue_empty_busy", busy, 0);

`ifdef AUTO_SWEEP_EN
        // Sweep across every router with ready tied high
        ready_all = 1'b1;
        for (int i = 0; i < NR; i++) expect_pkt(i, 14'h1234, 1, (i == 0) ? -1 : GAPC + 1);
        @(negedge clk);
        sweep_data  = 14'h1234;
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        check("sw_busy", busy, 1);
        wait_idle("sw", 2000);
        check("sw_inj_count", inj_count, 81);
        ready_all = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
